op_acc: RTL and testbench

OP_ACC -- requirements
Module: op_acc

---
 rtl/op_pkg.sv | 40 ++++
 rtl/op_add.sv | 51 +++++
 rtl/op_acc.sv | 154 +++++++++++++++
 tb/tb_op_acc.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/op_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : op_pkg
//  Purpose  : Shared types and helpers for the operand accumulator:
//             FSM state encoding, latched mode record and saturation limits.
//  Revision : 1.0 - initial release
// ============================================================================
package op_pkg;

    // Accumulator sequence states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Arithmetic mode captured on the first beat of a sequence
    typedef struct packed {
        logic is_signed;
        logic saturate;
    } mode_t;

    localparam int unsigned C_LIMIT_W = 64;

    // Largest representable value for an n-bit operand (callers truncate to n bits)
    function automatic logic [C_LIMIT_W-1:0] sat_max(input int unsigned n, input logic sgn);
        logic [C_LIMIT_W-1:0] one;
        one = {{(C_LIMIT_W-1){1'b0}}, 1'b1};
        return sgn ? ((one << (n - 1)) - one) : ((one << n) - one);
    endfunction

    // Smallest representable value for an n-bit operand (callers truncate to n bits)
    function automatic logic [C_LIMIT_W-1:0] sat_min(input int unsigned n, input logic sgn);
        logic [C_LIMIT_W-1:0] one;
        one = {{(C_LIMIT_W-1){1'b0}}, 1'b1};
        return sgn ? (one << (n - 1)) : {C_LIMIT_W{1'b0}};
    endfunction

endpackage
`default_nettype wire

// File: rtl/op_add.sv
`default_nettype none
// ============================================================================
//  Module   : op_add
//  Purpose  : Single N-bit add with overflow/underflow detection and optional
//             clamping; signedness and saturation fixed by parameters.
//  Revision : 1.0 - initial release
// ============================================================================
module op_add
    import op_pkg::*;
#(
    parameter int N        = 8,
    parameter bit SIGNED   = 1'b0,
    parameter bit SATURATE = 1'b0
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    output logic [N-1:0] sum_o,
    output logic         ov_o,
    output logic         uv_o
);

    localparam logic [N-1:0] C_MAX = N'(sat_max(N, SIGNED));
    localparam logic [N-1:0] C_MIN = N'(sat_min(N, SIGNED));

    logic [N:0]   full_w;
    logic [N-1:0] wrap_w;
    logic         s_ov_w;
    logic         s_uv_w;

    assign full_w = {1'b0, a_i} + {1'b0, b_i};
    assign wrap_w = full_w[N-1:0];

    // Two's-complement: sign of result disagrees with the common operand sign
    assign s_ov_w = ~a_i[N-1] & ~b_i[N-1] &  wrap_w[N-1];
    assign s_uv_w =  a_i[N-1] &  b_i[N-1] & ~wrap_w[N-1];

    assign ov_o = SIGNED ? s_ov_w : full_w[N];
    assign uv_o = SIGNED ? s_uv_w : 1'b0;

    // Clamp to the mode's limits when saturating, otherwise pass the modulo sum
    always_comb begin
        sum_o = wrap_w;
        if (SATURATE && ov_o) begin
            sum_o = C_MAX;
        end else if (SATURATE && uv_o) begin
            sum_o = C_MIN;
        end
    end

endmodule
`default_nettype wire

// File: rtl/op_acc.sv
`default_nettype none
// ============================================================================
//  Module   : op_acc
//  Purpose  : Accumulates LEN operand beats into one N-bit result with
//             runtime-selected signed/unsigned and saturate/wrap arithmetic,
//             sticky overflow/underflow flags and valid/ready handshakes.
//  Revision : 1.0 - initial release
// ============================================================================
module op_acc
    import op_pkg::*;
#(
    parameter int N   = 8,
    parameter int LEN = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         cfg_signed,
    input  logic         cfg_saturate,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data,
    output logic         out_ov,
    output logic         out_uv
);

    localparam int CW = $clog2(LEN + 1);

    state_e        state_q, state_d;
    logic [N-1:0]  acc_q,   acc_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    mode_t         mode_q,  mode_d;
    logic          ov_q,    ov_d;
    logic          uv_q,    uv_d;
    logic          rdy_q,   rdy_d;
    logic          vld_q,   vld_d;

    logic [N-1:0]  add_sum_w [4];
    logic [3:0]    add_ov_w;
    logic [3:0]    add_uv_w;
    logic [1:0]    sel_w;
    logic          beat_w;
    logic          xfer_w;

    // One adder per mode combination; index = {signed, saturate}
    for (genvar m = 0; m < 4; m++) begin : g_mode
        op_add #(
            .N        (N),
            .SIGNED   ((m / 2) == 1),
            .SATURATE ((m % 2) == 1)
        ) u_add (
            .a_i   (acc_q),
            .b_i   (in_data),
            .sum_o (add_sum_w[m]),
            .ov_o  (add_ov_w[m]),
            .uv_o  (add_uv_w[m])
        );
    end

    assign sel_w     = {mode_q.is_signed, mode_q.saturate};

    // clr masks both handshakes in the same cycle so it wins over any transfer
    assign in_ready  = rdy_q & ~clr;
    assign out_valid = vld_q & ~clr;
    assign out_data  = acc_q;
    assign out_ov    = ov_q;
    assign out_uv    = uv_q;

    assign beat_w    = in_valid  & in_ready;
    assign xfer_w    = out_valid & out_ready;

    // Next-state and datapath decision for the sequence FSM
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        ov_d    = ov_q;
        uv_d    = uv_q;
        if (clr) begin
            state_d = ST_IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            ov_d    = 1'b0;
            uv_d    = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (beat_w) begin
                        acc_d   = in_data;
                        cnt_d   = CW'(1);
                        mode_d  = '{is_signed: cfg_signed, saturate: cfg_saturate};
                        ov_d    = 1'b0;
                        uv_d    = 1'b0;
                        state_d = ST_ACC;
                    end
                end
                ST_ACC: begin
                    if (beat_w) begin
                        acc_d = add_sum_w[sel_w];
                        ov_d  = ov_q | add_ov_w[sel_w];
                        uv_d  = uv_q | add_uv_w[sel_w];
                        cnt_d = cnt_q + CW'(1);
                        if (cnt_q == CW'(LEN - 1)) begin
                            state_d = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (xfer_w) begin
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Handshake outputs are registered from the next state
    assign rdy_d = (state_d != ST_DONE);
    assign vld_d = (state_d == ST_DONE);

    // Sequence state registers; reset discards any partial sequence
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            mode_q  <= '0;
            ov_q    <= 1'b0;
            uv_q    <= 1'b0;
            rdy_q   <= 1'b0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            ov_q    <= ov_d;
            uv_q    <= uv_d;
            rdy_q   <= rdy_d;
            vld_q   <= vld_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_op_acc.sv
`default_nettype none
// ============================================================================
//  Module   : tb_op_acc
//  Purpose  : Scoreboard bench for op_acc: arithmetic reference model feeds an
//             expected-result queue, an output monitor pops and compares.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_op_acc;

    localparam int N   = 8;
    localparam int LEN = 4;

    typedef struct packed {
        logic [N-1:0] d;
        logic         ov;
        logic         uv;
    } res_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         clr = 1'b0;
    logic         cfg_signed = 1'b0;
    logic         cfg_saturate = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [N-1:0] in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [N-1:0] out_data;
    logic         out_ov;
    logic         out_uv;

    int   n_pass  = 0;
    int   n_total = 0;
    bit   rand_rdy = 1'b0;
    res_t exp_q[$];
    res_t mon_e;

    // Reference model state: values held as plain integers
    int     m_cnt = 0;
    longint m_acc = 0;
    bit     m_sgn = 0;
    bit     m_sat = 0;
    bit     m_ov  = 0;
    bit     m_uv  = 0;

    op_acc #(.N(N), .LEN(LEN)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr          (clr),
        .cfg_signed   (cfg_signed),
        .cfg_saturate (cfg_saturate),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_ov       (out_ov),
        .out_uv       (out_uv)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input bit ok, input longint act, input longint exp);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic longint to_val(input logic [N-1:0] x, input bit sgn);
        return sgn ? longint'($signed(x)) : longint'(x);
    endfunction

    // Mathematical accumulation: exact integer sum, then range check
    function automatic void model_beat(input logic [N-1:0] x);
        longint s, hi, lo, span;
        span = longint'(1) << N;
        if (m_cnt == 0) begin
            m_sgn = cfg_signed;
            m_sat = cfg_saturate;
            m_ov  = 0;
            m_uv  = 0;
            m_acc = to_val(x, m_sgn);
            m_cnt = 1;
        end else begin
            hi = m_sgn ? (span / 2) - 1 : span - 1;
            lo = m_sgn ? -(span / 2)    : 0;
            s  = m_acc + to_val(x, m_sgn);
            if (s > hi) begin
                m_ov  = 1;
                m_acc = m_sat ? hi : s - span;
            end else if (s < lo) begin
                m_uv  = 1;
                m_acc = m_sat ? lo : s + span;
            end else begin
                m_acc = s;
            end
            m_cnt++;
            if (m_cnt == LEN) begin
                exp_q.push_back('{d: m_acc[N-1:0], ov: m_ov, uv: m_uv});
                m_cnt = 0;
            end
        end
    endfunction

    // Result monitor: a transfer happens at the next edge when both are high
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 1'b0, longint'({out_data, out_ov, out_uv}), 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("result", {out_data, out_ov, out_uv} == mon_e,
                      longint'({out_data, out_ov, out_uv}), longint'(mon_e));
            end
        end
    end

    // Random consumer backpressure during the random phase
    always @(posedge clk) begin
        if (rand_rdy) begin
            #1;
            out_ready = ($urandom_range(0, 2) != 0);
        end
    end

    // Offer one beat and wait (bounded) until it is accepted
    task automatic beat(input logic [N-1:0] x, input bit keep);
        int waited;
        bit done;
        waited   = 0;
        done     = 0;
        in_valid = 1'b1;
        in_data  = x;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                model_beat(x);
                done = 1;
            end
            @(posedge clk); #1;
            if (!done) begin
                waited++;
                if (waited > 100) begin
                    check("beat_timeout", 1'b0, 0, 1);
                    done = 1;
                end
            end
        end
        in_valid = keep;
    endtask

    // Check the presented result against fixed values, then accept it
    task automatic finish_check(input string name, input logic [N-1:0] ed, input bit eov, input bit euv);
        @(negedge clk);
        check(name, out_valid && out_data == ed && out_ov == eov && out_uv == euv,
              longint'({out_valid, out_data, out_ov, out_uv}), longint'({1'b1, ed, eov, euv}));
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic dir_seq(input string name, input bit sgn, input bit sat,
                           input logic [N-1:0] a, input logic [N-1:0] b,
                           input logic [N-1:0] c, input logic [N-1:0] d,
                           input logic [N-1:0] ed, input bit eov, input bit euv);
        cfg_signed   = sgn;
        cfg_saturate = sat;
        out_ready    = 1'b0;
        beat(a, 1); beat(b, 1); beat(c, 1); beat(d, 0);
        finish_check(name, ed, eov, euv);
    endtask

    // Abort pulse; any pending or partial result is dropped from the model
    task automatic do_clr(input bit with_beat);
        clr = 1'b1;
        if (with_beat) begin
            in_valid = 1'b1;
            in_data  = N'($urandom_range(0, (1 << N) - 1));
        end
        @(negedge clk);
        check("clr_blocks", !in_ready && !out_valid, longint'({in_ready, out_valid}), 0);
        @(posedge clk); #1;
        clr      = 1'b0;
        in_valid = 1'b0;
        if (exp_q.size() > 0) void'(exp_q.pop_back());
        m_cnt = 0;
    endtask

    function automatic logic [N-1:0] pick_data();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return {1'b0, {(N-1){1'b1}}};
            2:       return {1'b1, {(N-1){1'b0}}};
            3:       return '1;
            default: return N'($urandom_range(0, (1 << N) - 1));
        endcase
    endfunction

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check("reset_state", !in_ready && !out_valid && out_data == '0 && !out_ov && !out_uv,
              longint'({in_ready, out_valid, out_data, out_ov, out_uv}), 0);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("ready_after_reset", in_ready && !out_valid, longint'({in_ready, out_valid}), 2);
        @(posedge clk); #1;

        // Arithmetic corner sequences
        dir_seq("uns_wrap",      0, 0, 8'd200, 8'd100, 8'd0,   8'd0,   8'd44,  1, 0);
        dir_seq("sgn_sat_ov",    1, 1, 8'd100, 8'd100, 8'h80,  8'd0,   8'hFF,  1, 0);
        dir_seq("uns_sat",       0, 1, 8'd250, 8'd10,  8'd1,   8'd1,   8'd255, 1, 0);
        dir_seq("sgn_sat_uv",    1, 1, 8'h9C,  8'h9C,  8'd0,   8'd127, 8'hFF,  0, 1);
        dir_seq("sgn_wrap_both", 1, 0, 8'd100, 8'd100, 8'h80,  8'd0,   8'h48,  1, 1);

        // Backpressure in DONE with the next sequence's first beat held valid
        cfg_signed = 0; cfg_saturate = 0; out_ready = 1'b0;
        beat(8'd1, 1); beat(8'd2, 1); beat(8'd3, 1); beat(8'd4, 1);
        in_data = 8'd5;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("backpressure_hold",
                  out_valid && !in_ready && out_data == 8'd10 && !out_ov && !out_uv,
                  longint'({out_valid, in_ready, out_data, out_ov, out_uv}),
                  longint'({1'b1, 1'b0, 8'd10, 1'b0, 1'b0}));
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        beat(8'd5, 1); beat(8'd6, 1); beat(8'd7, 1); beat(8'd8, 0);
        finish_check("after_backpressure", 8'd26, 0, 0);

        // Abort mid-sequence, with a competing beat
        beat(8'd7, 1); beat(8'd9, 1);
        do_clr(1);
        dir_seq("after_clr", 0, 0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd10, 0, 0);

        // Abort in DONE while the consumer is ready
        beat(8'd1, 1); beat(8'd1, 1); beat(8'd1, 1); beat(8'd1, 0);
        out_ready = 1'b1;
        do_clr(0);
        @(negedge clk);
        check("clr_drops_result", !out_valid && in_ready, longint'({out_valid, in_ready}), 1);
        @(posedge clk); #1;
        out_ready = 1'b0;

        // Reset pulse mid-sequence
        beat(8'd7, 1); beat(8'd9, 0);
        rst_n = 1'b0;
        #2;
        check("reset_midseq", !in_ready && !out_valid && out_data == '0,
              longint'({in_ready, out_valid, out_data}), 0);
        #1;
        rst_n = 1'b1;
        m_cnt = 0;
        @(posedge clk); #1;
        dir_seq("after_reset", 0, 0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd10, 0, 0);

        // Randomized sequences, cfg toggling every beat, random gaps and aborts
        rand_rdy = 1'b1;
        for (int s = 0; s < 40; s++) begin
            for (int b = 0; b < LEN; b++) begin
                cfg_signed   = $urandom_range(0, 1) != 0;
                cfg_saturate = $urandom_range(0, 1) != 0;
                if ($urandom_range(0, 3) == 0) begin
                    in_valid = 1'b0;
                    repeat ($urandom_range(1, 3)) begin
                        @(posedge clk); #1;
                    end
                end
                if ($urandom_range(0, 24) == 0) do_clr(1);
                beat(pick_data(), 1);
            end
        end
        in_valid = 1'b0;
        rand_rdy = 1'b0;
        @(posedge clk); #2;
        out_ready = 1'b1;
        for (int w = 0; w < 50 && exp_q.size() != 0; w++) begin
            @(posedge clk);
        end
        @(negedge clk);
        check("drain", exp_q.size() == 0, longint'(exp_q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
